muldiv_iter: RTL and testbench
==============================

// Module: muldiv_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit for the RV32M/RV64M extension.
//  It sits beside the ALU in the execute stage. It latches operands on a start strobe
//  and runs a shift-add multiplier (MUL_STEP bits/cycle) or a restoring divider
//  (1 bit/cycle). It returns a registered result with a one-cycle valid pulse.
//  It adds full RISC-V div-by-zero/overflow semantics and a pipeline kill.
// PARAMETERS
//  XLEN      32  operand/result width; power of two, >= 8
//  MUL_STEP  1   multiplier bits consumed per cycle; one of 1,2,4,8; divides XLEN
// PORTS
//  i_clk_n   in   1     clock; all state updates on posedge
//  i_rst     in   1     asynchronous active-high reset
//  i_in_a    in   XLEN  rs1 operand (multiplicand / dividend)
//  i_in_b    in   XLEN  rs2 operand (multiplier / divisor)
//  i_funct3  in   3     RV M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                       100 DIV, 101 DIVU, 110 REM, 111 REMU
//  i_start   in   1     request; accepted when o_busy=0
//  i_kill    in   1     abort in-flight op (pipeline flush)
//  o_result  out  XLEN  registered result; held until the next op completes
//  o_valid   out  1     one-cycle pulse: o_result updated this cycle
//  o_busy    out  1     op in flight; stall execute stage
// BEHAVIOUR
//  Reset (async, i_rst=1): state IDLE, o_result=0, o_valid=0, o_busy=0, counters 0.
//   Reset asserted mid-operation discards the op; no o_valid follows.
//  States: IDLE, MUL, DIV, FIX, DONE. o_busy=1 in MUL, DIV and FIX; o_valid=1 only in DONE.
//  Acceptance: i_start=1 and i_kill=0 in IDLE or DONE (back-to-back allowed).
//   Acceptance latches funct3, operand magnitudes and result sign. The inputs are don't-care
//   afterwards. i_start while o_busy=1 is ignored.
//  Transitions from acceptance edge E0:
//   div-by-zero or signed overflow -> FIX directly. Otherwise:
//   funct3[2]=0 -> MUL, with K=XLEN/MUL_STEP iterations.
//   funct3[2]=1 -> DIV, with XLEN iterations.
//   Each iteration takes one edge. The last iteration moves to FIX.
//   The FIX edge applies sign correction, registers o_result and enters DONE.
//   DONE lasts one cycle, then the FSM goes to IDLE unless a new start is accepted.
//  Latency (edges from E0 to o_valid high): MUL = XLEN/MUL_STEP+1; DIV = XLEN+1;
//   special cases = 1.
//  Signedness: MULH treats a and b as signed. MULHSU treats a as signed, b unsigned.
//   DIV and REM treat both as signed; the U forms are unsigned. MUL low word is sign-agnostic.
//  Arithmetic: magnitudes are XLEN-bit unsigned; |MIN_INT| = 2^(XLEN-1) is exact.
//   The product is 2*XLEN bits. MUL selects [XLEN-1:0]; MULH* select [2XLEN-1:XLEN].
//   Signed result = two's-complement negation of the full 2XLEN product.
//   Quotient sign = sa^sb. Remainder sign = sign of dividend.
//  Div by zero: quotient = all ones; remainder = dividend (unmodified).
//  Overflow (DIV/REM, a=MIN_INT, b=-1): quotient = MIN_INT; remainder = 0.
//  Kill: i_kill=1 on any edge with state != IDLE forces IDLE next.
//   o_valid is never asserted for the killed op, and o_result is unchanged.
//   Kill has priority over a same-cycle i_start; that start is dropped.
//   Kill in IDLE is a no-op.
//  o_result changes only on the FIX->DONE edge.
// TESTING
//  1 XLEN=32: MUL a=0xFFFFFFF9 b=3 -> 0xFFFFFFEB.
//    MULH with the same operands -> 0xFFFFFFFF.
//    Each o_valid arrives 33 edges after E0, and o_busy is high for 32+1 cycles.
//  2 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. With MUL_STEP=4 the same op completes in 9 edges.
//  3 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Both at 1 edge.
//  4 DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV -5/0 -> 0xFFFFFFFF. Each at 1 edge.
//  5 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REMU 100/7 -> 2. Each at 33 edges.
//    Issue them back-to-back with i_start in the DONE cycle: no bubble, three o_valid pulses.
//  6 Kill at DIV iteration 10 -> no o_valid, o_busy=0 next cycle, o_result holds the prior value.
//    Async i_rst mid-MUL -> all outputs 0 immediately. A subsequent start completes correctly.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier (MUL_STEP bits/cycle)
// and restoring divider (1 bit/cycle), with RISC-V div-by-zero/overflow results and kill.
module muldiv_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            i_clk_n,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_in_a,
  input  logic [XLEN-1:0] i_in_b,
  input  logic [2:0]      i_funct3,
  input  logic            i_start,
  input  logic            i_kill,
  output logic [XLEN-1:0] o_result,
  output logic            o_valid,
  output logic            o_busy
);

  localparam int K  = XLEN / MUL_STEP;
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] op_q, op_d;     // multiplicand (MUL) or divisor (DIV) magnitude
  logic [XLEN-1:0] hi_q, hi_d;     // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;     // multiplier / quotient shift register / special result
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic                   signed_a, signed_b, sa, sb;
  logic [XLEN-1:0]        a_mag, b_mag;
  logic                   is_div, b_zero, ovf, accept;
  logic [XLEN+MUL_STEP-1:0] mul_sum;
  logic [XLEN:0]          div_sh, div_diff;
  logic                   div_ge;
  logic [2*XLEN-1:0]      prod, prod_fix;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    f3_d      = f3_q;
    neg_d     = neg_q;
    special_d = special_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    signed_a = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
               (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    signed_b = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    sa       = signed_a & i_in_a[XLEN-1];
    sb       = signed_b & i_in_b[XLEN-1];
    a_mag    = sa ? -i_in_a : i_in_a;
    b_mag    = sb ? -i_in_b : i_in_b;
    is_div   = i_funct3[2];
    b_zero   = (i_in_b == '0);
    ovf      = is_div && !i_funct3[0] && (i_in_a == MIN_INT) && (i_in_b == ALL_ONES);
    accept   = ((state_q == S_IDLE) || (state_q == S_DONE)) && i_start && !i_kill;

    mul_sum  = {{MUL_STEP{1'b0}}, hi_q} +
               ({{MUL_STEP{1'b0}}, op_q} * {{XLEN{1'b0}}, lo_q[MUL_STEP-1:0]});
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, op_q};
    div_ge   = !div_diff[XLEN];
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;

    case (state_q)
      S_MUL: begin
        hi_d = mul_sum[XLEN+MUL_STEP-1:MUL_STEP];
        lo_d = XLEN'({mul_sum[MUL_STEP-1:0], lo_q} >> MUL_STEP);
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_DIV: begin
        hi_d = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], div_ge};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIX: begin
        state_d = S_DONE;
        if (special_q)                    result_d = lo_q;
        else if (!f3_q[2])                result_d = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                                          : prod_fix[2*XLEN-1:XLEN];
        else if (!f3_q[1])                result_d = neg_q ? -lo_q : lo_q;
        else                              result_d = neg_q ? -hi_q : hi_q;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Operands are captured in IDLE or DONE; a DONE-cycle start chains with no bubble.
    if (accept) begin
      f3_d      = i_funct3;
      special_d = is_div && (b_zero || ovf);
      hi_d      = '0;
      if (is_div) begin
        op_d  = b_mag;
        lo_d  = a_mag;
        neg_d = i_funct3[1] ? sa : (sa ^ sb);
        cnt_d = CW'(XLEN - 1);
      end else begin
        op_d  = a_mag;
        lo_d  = b_mag;
        neg_d = sa ^ sb;
        cnt_d = CW'(K - 1);
      end
      if (is_div && b_zero) begin
        lo_d    = i_funct3[1] ? i_in_a : ALL_ONES;
        state_d = S_FIX;
      end else if (ovf) begin
        lo_d    = i_funct3[1] ? '0 : MIN_INT;
        state_d = S_FIX;
      end else begin
        state_d = is_div ? S_DIV : S_MUL;
      end
    end

    // Kill outranks everything, including a same-cycle start and the FIX result write.
    if (i_kill && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge i_clk_n or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      f3_q      <= f3_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign o_result = result_q;
  assign o_valid  = (state_q == S_DONE);
  assign o_busy   = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed-vector bench for muldiv_iter: one MUL_STEP=1 instance and one MUL_STEP=4 instance.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_a = '0, in_b = '0;
  logic [2:0]  funct3 = '0;
  logic        start = 1'b0, start4 = 1'b0, kill = 1'b0;
  logic [31:0] res, res4;
  logic        valid, valid4, busy, busy4;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(32), .MUL_STEP(1)) u_dut (
    .i_clk_n(clk), .i_rst(rst), .i_in_a(in_a), .i_in_b(in_b), .i_funct3(funct3),
    .i_start(start), .i_kill(kill), .o_result(res), .o_valid(valid), .o_busy(busy)
  );

  muldiv_iter #(.XLEN(32), .MUL_STEP(4)) u_dut4 (
    .i_clk_n(clk), .i_rst(rst), .i_in_a(in_a), .i_in_b(in_b), .i_funct3(funct3),
    .i_start(start4), .i_kill(kill), .o_result(res4), .o_valid(valid4), .o_busy(busy4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; the next edge is the acceptance edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input bit use4);
    in_a   = a;
    in_b   = b;
    funct3 = f3;
    if (use4) start4 = 1'b1;
    else      start  = 1'b1;
  endtask

  // Returns positioned in the o_valid cycle, so a following issue() is back-to-back.
  task automatic wait_result(input string tag, input bit use4, input logic [31:0] exp,
                             input int exp_lat);
    int edges;
    int busy_n;
    @(posedge clk); #1;
    start  = 1'b0;
    start4 = 1'b0;
    edges  = 0;
    busy_n = 0;
    while (!(use4 ? valid4 : valid) && edges < 200) begin
      if (use4 ? busy4 : busy) busy_n++;
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_result"}, use4 ? res4 : res, exp);
    check({tag, "_latency"}, edges, exp_lat);
    check({tag, "_busy_cycles"}, busy_n, exp_lat);
    check({tag, "_busy_in_done"}, use4 ? busy4 : busy, 1'b0);
  endtask

  initial begin
    int pulses;
    int busy_seen;

    #1;
    check("rst_result", res, 32'h0);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    check("rst_held_busy", busy, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Multiplies, MUL_STEP=1
    issue(32'hFFFF_FFF9, 32'd3, 3'b000, 0); wait_result("mul",        0, 32'hFFFF_FFEB, 33);
    issue(32'hFFFF_FFF9, 32'd3, 3'b001, 0); wait_result("mulh",       0, 32'hFFFF_FFFF, 33);
    issue(32'hFFFF_FFF9, 32'd3, 3'b011, 0); wait_result("mulhu_a",    0, 32'h0000_0002, 33);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 0); wait_result("mulhsu", 0, 32'hFFFF_FFFF, 33);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 0); wait_result("mulhu_b", 0, 32'hFFFF_FFFE, 33);
    @(posedge clk); #1;
    check("valid_single_pulse", valid, 1'b0);

    // MUL_STEP=4 instance
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 1); wait_result("mulhu_s4", 1, 32'hFFFF_FFFE, 9);
    issue(32'h1234_5678, 32'h10, 3'b000, 1);        wait_result("mul_s4",   1, 32'h2345_6780, 9);

    // Overflow and divide-by-zero
    issue(32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 0); wait_result("div_ovf",  0, 32'h8000_0000, 1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 0); wait_result("rem_ovf",  0, 32'h0000_0000, 1);
    issue(32'd7, 32'd0, 3'b101, 0);                 wait_result("divu_z",   0, 32'hFFFF_FFFF, 1);
    issue(32'd7, 32'd0, 3'b111, 0);                 wait_result("remu_z",   0, 32'h0000_0007, 1);
    issue(32'hFFFF_FFFB, 32'd0, 3'b100, 0);         wait_result("div_z",    0, 32'hFFFF_FFFF, 1);
    issue(32'hFFFF_FFFB, 32'd0, 3'b110, 0);         wait_result("rem_z",    0, 32'hFFFF_FFFB, 1);

    // Regular divides, issued back-to-back in each DONE cycle
    issue(32'hFFFF_FFF9, 32'd2, 3'b100, 0); wait_result("div_neg",  0, 32'hFFFF_FFFD, 33);
    issue(32'hFFFF_FFF9, 32'd2, 3'b110, 0); wait_result("rem_neg",  0, 32'hFFFF_FFFF, 33);
    issue(32'd100, 32'd7, 3'b101, 0);       wait_result("divu",     0, 32'h0000_000E, 33);
    issue(32'd100, 32'd7, 3'b111, 0);       wait_result("remu",     0, 32'h0000_0002, 33);

    // Kill before DIV iteration 10, with a competing start that must be dropped
    issue(32'd1000, 32'd3, 3'b101, 0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    issue(32'd9, 32'd3, 3'b101, 0);
    @(posedge clk); #1;
    kill  = 1'b0;
    start = 1'b0;
    check("kill_busy", busy, 1'b0);
    check("kill_valid", valid, 1'b0);
    check("kill_result_held", res, 32'h0000_0002);
    pulses    = 0;
    busy_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) pulses++;
      if (busy)  busy_seen++;
    end
    check("kill_no_valid", pulses, 0);
    check("kill_start_dropped", busy_seen, 0);
    check("kill_result_after", res, 32'h0000_0002);

    // Asynchronous reset mid-MUL
    issue(32'd5, 32'd6, 3'b000, 0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_result", res, 32'h0);
    check("arst_valid", valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_result4", res4, 32'h0);
    @(negedge clk) rst = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    check("arst_no_valid", pulses, 0);
    issue(32'd5, 32'd6, 3'b000, 0); wait_result("mul_after_rst", 0, 32'd30, 33);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
